// File: rtl/pipelined_alu_muldiv.sv
// Execute unit: single-cycle ALU ops plus iterative RV32M-style mul/div,
// with valid/ready handshakes on the operand and result sides.
module pipelined_alu_muldiv #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [3:0]            ALU_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  eq,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [3:0]             op_q;      // captured opcode of the iterative op
  logic [W-1:0]           b_q;       // multiplicand (mul) or divisor magnitude (div)
  logic [W-1:0]           acc_hi;    // product high half / partial remainder
  logic [W-1:0]           acc_lo;    // product low half+multiplier / quotient+dividend
  logic [SHAMT_WIDTH-1:0] count;
  logic                   neg_q, neg_r, div_zero;

  logic                   accept;
  logic                   is_mul, is_div, is_sdiv, a_neg, b_neg;
  logic [W-1:0]           a_mag, b_mag, alu_res;
  logic [W:0]             mul_sum, div_shift;
  logic [W-1:0]           mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, fin_res;
  logic                   div_ge;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign accept    = in_valid && in_ready;

  // Operand-side decode: iterative class and signed-divide magnitudes.
  assign is_mul  = (ALU_ctrl[3:1] == 3'b101);
  assign is_div  = (ALU_ctrl[3:2] == 2'b11);
  assign is_sdiv = is_div && !ALU_ctrl[0];
  assign a_neg   = is_sdiv && op1[W-1];
  assign b_neg   = is_sdiv && op2[W-1];
  assign a_mag   = a_neg ? -op1 : op1;
  assign b_mag   = b_neg ? -op2 : op2;

  // Single-cycle ALU result for opcodes 0-9.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // alu_res unassigned, which would otherwise infer a latch.
    alu_res = '0;
    case (ALU_ctrl)
      4'd0: alu_res = op1 + op2;
      4'd1: alu_res = op1 - op2;
      4'd2: alu_res = op1 & op2;
      4'd3: alu_res = op1 | op2;
      4'd4: alu_res = op1 ^ op2;
      4'd5: alu_res = op1 << op2[SHAMT_WIDTH-1:0];
      4'd6: alu_res = op1 >> op2[SHAMT_WIDTH-1:0];
      4'd7: alu_res = $signed(op1) >>> op2[SHAMT_WIDTH-1:0];
      4'd8: alu_res = {{(W-1){1'b0}}, $signed(op1) < $signed(op2)};
      4'd9: alu_res = {{(W-1){1'b0}}, op1 < op2};
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
    mul_hi_n  = mul_sum[W:1];
    mul_lo_n  = {mul_sum[0], acc_lo[W-1:1]};
    div_shift = {acc_hi, acc_lo[W-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    // The partial remainder after a successful subtract is below the divisor,
    // so a W-bit modulo subtraction is exact.
    div_hi_n  = div_ge ? (div_shift[W-1:0] - b_q) : div_shift[W-1:0];
    div_lo_n  = {acc_lo[W-2:0], div_ge};
  end

  // Final iterative result, including sign fix-up and divide-by-zero.
  always_comb begin
    fin_res = '0;
    if (!op_q[2])      fin_res = op_q[0] ? mul_hi_n : mul_lo_n;
    else if (!op_q[1]) fin_res = div_zero ? '1 : (neg_q ? -div_lo_n : div_lo_n);
    else               fin_res = neg_r ? -div_hi_n : div_hi_n;
  end

  // Control FSM, iteration datapath and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= IDLE;
      op_q     <= '0;
      b_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      ALUout   <= '0;
      eq       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            eq <= (op1 == op2);
            if (is_mul || is_div) begin
              state    <= BUSY;
              count    <= '0;
              op_q     <= ALU_ctrl;
              b_q      <= is_mul ? op1 : b_mag;
              acc_lo   <= is_mul ? op2 : a_mag;
              acc_hi   <= '0;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= (op2 == '0);
            end else begin
              state  <= DONE;
              ALUout <= alu_res;
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc_hi <= op_q[2] ? div_hi_n : mul_hi_n;
          acc_lo <= op_q[2] ? div_lo_n : mul_lo_n;
          count  <= count + 1'b1;
          if (count == SHAMT_WIDTH'(W - 1)) begin
            state  <= DONE;
            ALUout <= fin_res;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_alu_muldiv.sv
// Directed self-checking bench for pipelined_alu_muldiv (DATA_WIDTH=32).
module tb_pipelined_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1, op2;
  logic [3:0]  ALU_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUout;
  logic        eq;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pipelined_alu_muldiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .ALU_ctrl(ALU_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUout(ALUout), .eq(eq), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until accepted; returns in the cycle after accept
  // with the operand inputs scrambled to prove they were captured.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1;
    ALU_ctrl = op;
    op1      = a;
    op2      = b;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("accept_wait_bounded", 32'(n < 100), 32'd1);
    step();
    in_valid = 1'b0;
    op1      = $urandom;
    op2      = $urandom;
    ALU_ctrl = 4'($urandom);
  endtask

  // Counts cycles from accept until out_valid, plus BUSY behaviour on the way.
  task automatic wait_result(output int lat, output int busy_cnt, output int ready_in_busy);
    lat = 1;
    busy_cnt = 0;
    ready_in_busy = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      if (busy && in_ready) ready_in_busy++;
      step();
      lat++;
    end
  endtask

  task automatic run_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_eq);
    int lat, bc, rb;
    string t;
    t = $sformatf("op%0d %08h,%08h", op, a, b);
    issue(op, a, b);
    wait_result(lat, bc, rb);
    check({t, " result"}, ALUout, exp_res);
    check({t, " eq"}, {31'd0, eq}, {31'd0, exp_eq});
    check({t, " latency"}, 32'(lat), (op >= 4'd10) ? 32'd33 : 32'd1);
    if (op >= 4'd10) begin
      check({t, " busy_cycles"}, 32'(bc), 32'd32);
      check({t, " in_ready_in_busy"}, 32'(rb), 32'd0);
    end
  endtask

  initial begin
    int bad, seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; ALU_ctrl = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst busy",      {31'd0, busy},      32'd0);
    check("rst in_ready",  {31'd0, in_ready},  32'd1);
    check("rst ALUout",    ALUout,             32'd0);
    check("rst eq",        {31'd0, eq},        32'd0);

    // Base ALU
    run_vec(4'd0, 32'd5, 32'd7, 32'd12, 1'b0);
    run_vec(4'd1, 32'd9, 32'd9, 32'd0, 1'b1);
    run_vec(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
    run_vec(4'd3, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0);
    run_vec(4'd5, 32'd1, 32'd35, 32'd8, 1'b0);
    run_vec(4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    run_vec(4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    run_vec(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    run_vec(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);

    // Multiply
    run_vec(4'd10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0);
    run_vec(4'd11, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0);
    run_vec(4'd10, 32'h1234_5678, 32'h10, 32'h2345_6780, 1'b0);
    run_vec(4'd11, 32'h1234_5678, 32'h10, 32'h0000_0001, 1'b0);

    // Divide
    run_vec(4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_vec(4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_vec(4'd12, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run_vec(4'd14, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_vec(4'd13, 32'd100, 32'd7, 32'd14, 1'b0);
    run_vec(4'd15, 32'd100, 32'd7, 32'd2, 1'b0);
    run_vec(4'd13, 32'd5, 32'd5, 32'd1, 1'b1);

    // Divide special cases
    run_vec(4'd13, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_vec(4'd14, 32'd9, 32'd0, 32'd9, 1'b0);
    run_vec(4'd12, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_vec(4'd14, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0);
    run_vec(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_vec(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Backpressure, then consume with a simultaneous accept
    step();
    out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd4);
    check("bp first result", ALUout, 32'd7);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ALUout !== 32'd7 || eq !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("bp held cycles bad", 32'(bad), 32'd0);
    in_valid = 1'b1; ALU_ctrl = 4'd4; op1 = 32'hF0; op2 = 32'h0F; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("b2b out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b ALUout",    ALUout,             32'h0000_00FF);
    check("b2b eq",        {31'd0, eq},        32'd0);
    step();

    // Reset in the 10th BUSY cycle of a DIV
    issue(4'd12, 32'd100, 32'd3);
    repeat (9) step();
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst busy",      {31'd0, busy},      32'd0);
    check("midrst ALUout",    ALUout,             32'd0);
    check("midrst in_ready",  {31'd0, in_ready},  32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      step();
    end
    check("midrst no result", 32'(seen), 32'd0);
    run_vec(4'd13, 32'd100, 32'd3, 32'd33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
